snake_ctrl: RTL

Game sequencer for the snake datapath. It generates the move tick and arbitrates IR remote codes into a committed direction, rejecting reversals. Before each move it checks for a wall collision, and after each move it scans the body serially for a self-collision. It sits between the IR decoder and the snake position datapath, and drives that datapath's step enable, direction and re-init pulse.

---
 rtl/snake_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_ctrl.sv
// Game sequencer for the snake datapath: move tick, IR direction arbitration,
// wall check before each move and serial self-collision scan after it.
module snake_ctrl #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter logic [31:0] UP       = 32'h20DF6A95,
    parameter logic [31:0] DOWN     = 32'h20DFEA15,
    parameter logic [31:0] LEFT     = 32'h20DF1AE5,
    parameter logic [31:0] RIGHT    = 32'h20DF9A65
) (
    input  logic        game_clk,
    input  logic        reset,
    input  logic [31:0] ir_code,
    input  logic        ir_valid,
    input  logic [7:0]  head_pos,
    input  logic [7:0]  length,
    input  logic [7:0]  body_pos,
    output logic [7:0]  body_idx,
    output logic        step,
    output logic [1:0]  dir,
    output logic        snake_reset,
    output logic [2:0]  state,
    output logic        game_over,
    output logic [7:0]  score
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_STEP  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    // Returns {is_direction, direction} for a raw IR code.
    function automatic logic [2:0] decode_ir(input logic [31:0] code);
        logic [2:0] res;
        case (code)
            UP:      res = 3'b100;
            DOWN:    res = 3'b101;
            LEFT:    res = 3'b110;
            RIGHT:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic wall_hit(input logic [1:0] d, input logic [7:0] pos);
        logic hit;
        case (d)
            2'b00:   hit = (pos < 8'd16);
            2'b01:   hit = (pos >= 8'd240);
            2'b10:   hit = (pos[3:0] == 4'd0);
            2'b11:   hit = (pos[3:0] == 4'd15);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t      r_state, w_state_nx;
    logic [1:0]  r_dir, w_dir_nx;
    logic [1:0]  r_pending, w_pending_nx;
    logic        r_step, w_step_nx;
    logic        r_snake_reset, w_snake_reset_nx;
    logic [7:0]  r_body_idx, w_body_idx_nx;
    logic        r_game_over;
    logic [7:0]  r_score, w_score_nx;
    logic [31:0] r_tick_cnt, w_tick_cnt_nx;

    logic [2:0]  w_ir_dec;
    logic        w_ir_dir;
    logic        w_ir_accept;
    logic        w_tick;
    logic [31:0] w_cnt_run;

    // Decode, reversal filter, and free-running tick counter value.
    always_comb begin
        w_ir_dec    = decode_ir(ir_code);
        w_ir_dir    = ir_valid & w_ir_dec[2];
        // Opposite direction differs only in the low bit (up/down, left/right).
        w_ir_accept = w_ir_dir & (w_ir_dec[1:0] != (r_dir ^ 2'b01));
        w_tick      = (r_state == S_PLAY) && (r_tick_cnt == TICK_LAST);
        w_cnt_run   = (r_tick_cnt == TICK_LAST) ? 32'd0 : (r_tick_cnt + 32'd1);
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx       = r_state;
        w_dir_nx         = r_dir;
        w_pending_nx     = r_pending;
        w_step_nx        = 1'b0;
        w_snake_reset_nx = 1'b0;
        w_body_idx_nx    = r_body_idx;
        w_score_nx       = r_score;
        w_tick_cnt_nx    = r_tick_cnt;
        case (r_state)
            S_IDLE: begin
                w_tick_cnt_nx = 32'd0;
                if (w_ir_dir) begin
                    w_dir_nx     = w_ir_dec[1:0];
                    w_pending_nx = w_ir_dec[1:0];
                    w_state_nx   = S_PLAY;
                end else begin
                    w_state_nx   = S_IDLE;
                end
            end
            S_PLAY: begin
                w_tick_cnt_nx = w_cnt_run;
                if (w_ir_accept) begin
                    w_pending_nx = w_ir_dec[1:0];
                end else begin
                    w_pending_nx = r_pending;
                end
                if (w_tick) begin
                    if (wall_hit(r_pending, head_pos)) begin
                        w_state_nx = S_OVER;
                    end else begin
                        w_dir_nx   = r_pending;
                        w_step_nx  = 1'b1;
                        w_state_nx = S_STEP;
                    end
                end else begin
                    w_state_nx = S_PLAY;
                end
            end
            S_STEP: begin
                w_tick_cnt_nx = w_cnt_run;
                if (w_ir_accept) begin
                    w_pending_nx = w_ir_dec[1:0];
                end else begin
                    w_pending_nx = r_pending;
                end
                w_body_idx_nx = 8'd1;
                w_state_nx    = S_CHECK;
            end
            S_CHECK: begin
                w_tick_cnt_nx = w_cnt_run;
                if (w_ir_accept) begin
                    w_pending_nx = w_ir_dec[1:0];
                end else begin
                    w_pending_nx = r_pending;
                end
                if (r_body_idx >= length) begin
                    w_score_nx = length - 8'd1;
                    w_state_nx = S_PLAY;
                end else if (body_pos == head_pos) begin
                    w_state_nx = S_OVER;
                end else begin
                    w_body_idx_nx = r_body_idx + 8'd1;
                end
            end
            S_OVER: begin
                w_tick_cnt_nx = 32'd0;
                if (w_ir_dir) begin
                    w_snake_reset_nx = 1'b1;
                    w_score_nx       = 8'd0;
                    w_dir_nx         = 2'b11;
                    w_pending_nx     = 2'b11;
                    w_state_nx       = S_IDLE;
                end else begin
                    w_state_nx       = S_OVER;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dir         <= 2'b11;
            r_pending     <= 2'b11;
            r_step        <= 1'b0;
            r_snake_reset <= 1'b0;
            r_body_idx    <= 8'd0;
            r_game_over   <= 1'b0;
            r_score       <= 8'd0;
            r_tick_cnt    <= 32'd0;
        end else begin
            r_state       <= w_state_nx;
            r_dir         <= w_dir_nx;
            r_pending     <= w_pending_nx;
            r_step        <= w_step_nx;
            r_snake_reset <= w_snake_reset_nx;
            r_body_idx    <= w_body_idx_nx;
            r_game_over   <= (w_state_nx == S_OVER);
            r_score       <= w_score_nx;
            r_tick_cnt    <= w_tick_cnt_nx;
        end
    end

    assign state       = r_state;
    assign dir         = r_dir;
    assign step        = r_step;
    assign snake_reset = r_snake_reset;
    assign body_idx    = r_body_idx;
    assign game_over   = r_game_over;
    assign score       = r_score;

endmodule
